// File: rtl/pcre_count_engine_pkg.sv
// Shared defaults and helpers for the counter-based payload matching engine.
package pcre_eng_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int POS_W_DEF = 16;
  localparam int UNBOUNDED = 0;
  localparam int VEC_MAX_W = 512;

  // Extract the w-bit field idx from a packed per-segment parameter vector.
  function automatic logic [31:0] vec_field(input logic [VEC_MAX_W-1:0] vec,
                                            input int idx, input int w);
    logic [VEC_MAX_W-1:0] sh;
    logic [31:0]          mask;
    sh   = vec >> (idx * w);
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/pcre_count_engine_if.sv
// Byte-stream / result bundle between the class decoder side and the engine.
interface pcre_count_engine_if #(
  parameter int NUM_SEG = 4,
  parameter int POS_W   = 16
);
  logic               en;
  logic               sod;
  logic [NUM_SEG-1:0] cls;
  logic               match;
  logic [POS_W-1:0]   match_pos;
  logic [NUM_SEG-1:0] active;

  modport master (output en, sod, cls, input match, match_pos, active);
  modport slave  (input en, sod, cls, output match, match_pos, active);
endinterface

// File: rtl/pcre_count_engine_seg.sv
// One repetition segment: run counter, active flag and continue/restart/drop rules.
module pcre_count_seg
  import pcre_eng_pkg::*;
#(
  parameter int             CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MIN_C = CNT_W'(1),
  parameter logic [CNT_W-1:0] MAX_C = CNT_W'(UNBOUNDED)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic entry_i,
  input  logic cls_i,
  output logic acc_o,
  output logic acc_nxt_o,
  output logic active_o
);

  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff_s;
  logic             active_q, active_d, active_eff_s;
  logic             room_s;

  // State as seen by this byte: a start-of-data byte wipes the run first.
  always_comb begin
    active_eff_s = active_q & ~clr_i;
    cnt_eff_s    = clr_i ? CNT_ZERO : cnt_q;
    room_s       = (MAX_C == CNT_W'(UNBOUNDED)) || (cnt_eff_s < MAX_C);
    acc_o        = active_eff_s && (cnt_eff_s >= MIN_C);
  end

  // Next run state: continue wins over restart, anything else drops the run.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (en_i) begin
      if (cls_i && active_eff_s && room_s) begin
        active_d = 1'b1;
        cnt_d    = (cnt_eff_s == CNT_SAT) ? CNT_SAT : cnt_eff_s + CNT_W'(1);
      end else if (cls_i && entry_i) begin
        active_d = 1'b1;
        cnt_d    = CNT_W'(1);
      end else begin
        active_d = 1'b0;
        cnt_d    = CNT_ZERO;
      end
    end else begin
      active_d = active_q;
      cnt_d    = cnt_q;
    end
  end

  assign acc_nxt_o = active_d && (cnt_d >= MIN_C);
  assign active_o  = active_q;

  // Run state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= CNT_ZERO;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/pcre_count_engine.sv
// Chain of bounded-repetition segments with byte offset tracking and sticky first-match capture.
module pcre_count_engine
  import pcre_eng_pkg::*;
#(
  parameter int                       NUM_SEG  = 4,
  parameter int                       CNT_W    = CNT_W_DEF,
  parameter logic [NUM_SEG*CNT_W-1:0] MIN_VEC  = {NUM_SEG{CNT_W'(1)}},
  parameter logic [NUM_SEG*CNT_W-1:0] MAX_VEC  = {(NUM_SEG*CNT_W){1'b0}},
  parameter bit                       ANCHORED = 1'b1,
  parameter int                       POS_W    = POS_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  pcre_count_engine_if.slave eng
);

  localparam logic [POS_W-1:0] POS_SAT  = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};

  logic               clr_s, start_s;
  logic [NUM_SEG-1:0] acc_s, acc_nxt_s, entry_s, active_s;
  logic [POS_W-1:0]   pos_q, pos_d, cur_pos_s;
  logic               match_q, match_d;
  logic [POS_W-1:0]   match_pos_q, match_pos_d;

  assign clr_s   = eng.en & eng.sod;
  assign start_s = ANCHORED ? clr_s : eng.en;

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
    if (g == 0) begin : g_first
      assign entry_s[g] = start_s;
    end else begin : g_chain
      assign entry_s[g] = acc_s[g-1];
    end

    pcre_count_seg #(
      .CNT_W (CNT_W),
      .MIN_C (CNT_W'(vec_field(VEC_MAX_W'(MIN_VEC), g, CNT_W))),
      .MAX_C (CNT_W'(vec_field(VEC_MAX_W'(MAX_VEC), g, CNT_W)))
    ) u_seg (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (eng.en),
      .clr_i     (clr_s),
      .entry_i   (entry_s[g]),
      .cls_i     (eng.cls[g]),
      .acc_o     (acc_s[g]),
      .acc_nxt_o (acc_nxt_s[g]),
      .active_o  (active_s[g])
    );
  end

  // Offset of the byte presented this cycle, saturating at the top of the range.
  always_comb begin
    if (eng.sod) begin
      cur_pos_s = POS_ZERO;
    end else if (pos_q == POS_SAT) begin
      cur_pos_s = POS_SAT;
    end else begin
      cur_pos_s = pos_q + POS_W'(1);
    end
    pos_d = eng.en ? cur_pos_s : pos_q;
  end

  // Sticky match: restart on sod, otherwise capture only the first completion.
  always_comb begin
    match_d     = match_q;
    match_pos_d = match_pos_q;
    if (eng.en) begin
      if (eng.sod) begin
        match_d     = acc_nxt_s[NUM_SEG-1];
        match_pos_d = POS_ZERO;
      end else if (!match_q && acc_nxt_s[NUM_SEG-1]) begin
        match_d     = 1'b1;
        match_pos_d = cur_pos_s;
      end else begin
        match_d     = match_q;
        match_pos_d = match_pos_q;
      end
    end else begin
      match_d     = match_q;
      match_pos_d = match_pos_q;
    end
  end

  // Offset and match result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= POS_ZERO;
      match_q     <= 1'b0;
      match_pos_q <= POS_ZERO;
    end else begin
      pos_q       <= pos_d;
      match_q     <= match_d;
      match_pos_q <= match_pos_d;
    end
  end

  assign eng.match     = match_q;
  assign eng.match_pos = match_pos_q;
  assign eng.active    = active_s;

endmodule

// File: tb/tb_pcre_count_engine.sv
// Bench for pcre_count_engine configured as ^\d+L\d{2,3} (anchored) and \d+L\d{2,3} (unanchored).
module tb_pcre_count_engine;

  localparam logic [23:0] MINV = {8'd2, 8'd1, 8'd1};
  localparam logic [23:0] MAXV = {8'd3, 8'd1, 8'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_s = 1'b0;
  logic       sod_s = 1'b0;
  logic [7:0] byte_s = 8'h00;

  always #5 clk = ~clk;

  function automatic bit is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  pcre_count_engine_if #(.NUM_SEG(3), .POS_W(16)) if_a ();
  pcre_count_engine_if #(.NUM_SEG(3), .POS_W(16)) if_b ();

  assign if_a.en  = en_s;
  assign if_a.sod = sod_s;
  assign if_a.cls = {is_digit(byte_s), byte_s == 8'h4C, is_digit(byte_s)};
  assign if_b.en  = en_s;
  assign if_b.sod = sod_s;
  assign if_b.cls = {is_digit(byte_s), byte_s == 8'h4C, is_digit(byte_s)};

  pcre_count_engine #(.NUM_SEG(3), .CNT_W(8), .MIN_VEC(MINV), .MAX_VEC(MAXV),
                      .ANCHORED(1'b1), .POS_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .eng(if_a));
  pcre_count_engine #(.NUM_SEG(3), .CNT_W(8), .MIN_VEC(MINV), .MAX_VEC(MAXV),
                      .ANCHORED(1'b0), .POS_W(16))
    dut_b (.clk(clk), .rst_n(rst_n), .eng(if_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: bytes since the last sod/reset, matched against the regex directly.
  logic [7:0] q_buf[$];
  bit         seg_sod = 1'b0;
  bit         ma = 1'b0, mb = 1'b0;
  int         pa = 0, pb = 0;
  int         posctr = 0;

  function automatic bit regex_end(input bit anch);
    int e, t;
    e = q_buf.size() - 1;
    t = 0;
    while (t <= e && is_digit(q_buf[e-t])) t++;
    if (t < 2 || t > 3) return 1'b0;
    if (e - t - 1 < 0) return 1'b0;
    if (q_buf[e-t] != 8'h4C) return 1'b0;
    if (!is_digit(q_buf[e-t-1])) return 1'b0;
    if (!anch) return 1'b1;
    for (int j = 0; j < e - t; j++) if (!is_digit(q_buf[j])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q_buf.delete();
    seg_sod = 1'b0; ma = 1'b0; mb = 1'b0; pa = 0; pb = 0; posctr = 0;
  endtask

  task automatic model_byte(input bit s, input logic [7:0] b);
    int cur;
    if (s) begin
      q_buf.delete();
      seg_sod = 1'b1; ma = 1'b0; mb = 1'b0; pa = 0; pb = 0;
      cur = 0;
    end else begin
      cur = (posctr < 65535) ? posctr + 1 : 65535;
    end
    posctr = cur;
    q_buf.push_back(b);
    if (!ma && seg_sod && regex_end(1'b1)) begin ma = 1'b1; pa = cur; end
    if (!mb && regex_end(1'b0)) begin mb = 1'b1; pb = cur; end
  endtask

  task automatic step(input bit e, input bit s, input logic [7:0] b);
    en_s = e; sod_s = s; byte_s = b;
    @(posedge clk);
    #1;
    if (e) model_byte(s, b);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_match_a"}, 32'(if_a.match), 32'(ma));
    chk({tag, "_pos_a"}, 32'(if_a.match_pos), 32'(pa));
    chk({tag, "_match_b"}, 32'(if_b.match), 32'(mb));
    chk({tag, "_pos_b"}, 32'(if_b.match_pos), 32'(pb));
  endtask

  typedef struct {
    bit         en;
    bit         sod;
    logic [7:0] ch;
    bit         m;
    int         p;
    logic [2:0] act;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit e, input bit s, input logic [7:0] c,
                              input bit m, input int p, input logic [2:0] a);
    vec_t v;
    v.en = e; v.sod = s; v.ch = c; v.m = m; v.p = p; v.act = a;
    tbl.push_back(v);
  endfunction

  initial begin
    int gap;
    logic [7:0] rb;
    int r;

    // "12L34" anchored, en gap, sod restart, no-sod byte
    add(1,1,"1",0,0,3'b001); add(1,0,"2",0,0,3'b001); add(1,0,"L",0,0,3'b010);
    add(1,0,"3",0,0,3'b100); add(1,0,"4",1,4,3'b100); add(0,0,"7",1,4,3'b100);
    add(1,1,"q",0,0,3'b000); add(1,0,"1",0,0,3'b000);
    // "12L3x" then "12L3456"
    add(1,1,"1",0,0,3'b001); add(1,0,"2",0,0,3'b001); add(1,0,"L",0,0,3'b010);
    add(1,0,"3",0,0,3'b100); add(1,0,"x",0,0,3'b000);
    add(1,1,"1",0,0,3'b001); add(1,0,"2",0,0,3'b001); add(1,0,"L",0,0,3'b010);
    add(1,0,"3",0,0,3'b100); add(1,0,"4",1,4,3'b100); add(1,0,"5",1,4,3'b100);
    add(1,0,"6",1,4,3'b000);
    // "x12L34": anchored never matches
    add(1,1,"x",0,0,3'b000); add(1,0,"1",0,0,3'b000); add(1,0,"2",0,0,3'b000);
    add(1,0,"L",0,0,3'b000); add(1,0,"3",0,0,3'b000); add(1,0,"4",0,0,3'b000);

    // reset state
    #2;
    chk("rst_match", 32'(if_a.match), 32'd0);
    chk("rst_pos", 32'(if_a.match_pos), 32'd0);
    chk("rst_active", 32'(if_a.active), 32'd0);
    #10;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].sod, tbl[i].ch);
      chk($sformatf("tbl%0d_match", i), 32'(if_a.match), 32'(tbl[i].m));
      chk($sformatf("tbl%0d_pos", i), 32'(if_a.match_pos), 32'(tbl[i].p));
      chk($sformatf("tbl%0d_active", i), 32'(if_a.active), 32'(tbl[i].act));
      check_model($sformatf("tbl%0d", i));
    end
    chk("unanch_x12L34_match", 32'(if_b.match), 32'd1);
    chk("unanch_x12L34_pos", 32'(if_b.match_pos), 32'd5);

    // "12L34" with random en gaps
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < 5; k++) begin
        rb = (k == 2) ? 8'h4C : ((k < 2) ? 8'(8'h31 + k) : 8'(8'h30 + k));
        step(1'b1, k == 0, rb);
        check_model("gap");
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'(8'h30 + $urandom_range(0, 9)));
      end
      chk("gap_match", 32'(if_a.match), 32'd1);
      chk("gap_pos", 32'(if_a.match_pos), 32'd4);
    end
    step(1'b1, 1'b1, "q");
    chk("sod_q_clear", 32'(if_a.match), 32'd0);
    check_model("sod_q");

    // 300 digits then "L12": seg 0 saturates and stays active
    for (int k = 0; k < 300; k++) step(1'b1, k == 0, 8'(8'h30 + (k % 10)));
    chk("sat_active0", 32'(if_a.active), 32'b001);
    step(1'b1, 1'b0, "L");
    step(1'b1, 1'b0, "1");
    chk("sat_nomatch_yet", 32'(if_a.match), 32'd0);
    step(1'b1, 1'b0, "2");
    chk("sat_match", 32'(if_a.match), 32'd1);
    chk("sat_pos", 32'(if_a.match_pos), 32'd302);
    check_model("sat");

    // async reset after a match, and again mid-run
    step(1'b1, 1'b1, "1"); step(1'b1, 1'b0, "2"); step(1'b1, 1'b0, "L");
    step(1'b1, 1'b0, "3"); step(1'b1, 1'b0, "4");
    check_model("pre_rst");
    en_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_match", 32'(if_a.match), 32'd0);
    chk("arst_pos", 32'(if_a.match_pos), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    step(1'b1, 1'b1, "1"); step(1'b1, 1'b0, "2"); step(1'b1, 1'b0, "L"); step(1'b1, 1'b0, "3");
    chk("pre_rst2_active", 32'(if_a.active), 32'b100);
    en_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_active_a", 32'(if_a.active), 32'd0);
    chk("arst2_active_b", 32'(if_b.active), 32'd0);
    chk("arst2_match", 32'(if_a.match), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, "4");
    chk("post_rst_nomatch_a", 32'(if_a.match), 32'd0);
    chk("post_rst_nomatch_b", 32'(if_b.match), 32'd0);
    check_model("post_rst");

    // randomized stream against the model
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 9);
      if (r < 6) rb = 8'(8'h30 + $urandom_range(0, 9));
      else if (r < 8) rb = 8'h4C;
      else rb = 8'h78;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rb);
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
